// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round sequencer around one shared, registered SubBytes unit.
// Optional abort input enabled by defining AES_ROUND_CTRL_ABORT_EN.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [0:127] i_plaintext,
  output logic         o_valid,
  input  logic         i_out_ready,
  output logic [0:127] o_ciphertext,
  output logic [3:0]   o_rk_index,
  input  logic [0:127] i_round_key,
  output logic         o_sb_active,
  output logic [0:127] o_sb_data,
  input  logic [0:127] i_sb_data
`ifdef AES_ROUND_CTRL_ABORT_EN
  ,
  input  logic         i_abort
`endif
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, SUB, MIX, DONE} state_e;

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [0:127] data_q, data_d;
  logic [0:127] sr_out, mc_out;
  logic         abort;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort = i_abort;
`else
  assign abort = 1'b0;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
  function automatic logic [0:127] shift_rows(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
    return o;
  endfunction

  function automatic logic [0:127] mix_columns(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(4*c)   +: 8];
      a1 = s[8*(4*c+1) +: 8];
      a2 = s[8*(4*c+2) +: 8];
      a3 = s[8*(4*c+3) +: 8];
      o[8*(4*c)   +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[8*(4*c+1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[8*(4*c+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[8*(4*c+3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  assign sr_out = shift_rows(i_sb_data);
  assign mc_out = mix_columns(sr_out);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      round_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    data_d       = data_q;
    o_ready      = 1'b0;
    o_valid      = 1'b0;
    o_sb_active  = 1'b0;
    o_rk_index   = '0;
    o_ciphertext = '0;
    o_sb_data    = data_q;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          data_d  = i_plaintext ^ i_round_key;
          round_d = 4'd1;
          state_d = SUB;
        end
      end
      SUB: begin
        o_sb_active = ~abort;
        o_rk_index  = round_q;
        state_d     = MIX;
      end
      MIX: begin
        // i_sb_data holds SubBytes(data_q) captured on the SUB edge.
        o_rk_index = round_q;
        if (round_q == LAST_ROUND) begin
          data_d  = sr_out ^ i_round_key;
          state_d = DONE;
        end else begin
          data_d  = mc_out ^ i_round_key;
          round_d = round_q + 4'd1;
          state_d = SUB;
        end
      end
      DONE: begin
        o_valid      = 1'b1;
        o_ciphertext = data_q;
        if (i_out_ready) begin
          state_d = IDLE;
          round_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      round_d = '0;
      data_d  = data_q;
    end
  end

endmodule
